// File: rtl/hazard_forward_unit_if.sv
// Bus between the ID-stage pipeline control and hazard_forward_unit.
// STALL_CNT is only present when HZ_STATS_EN is defined.
interface hazard_forward_unit_if #(
    parameter int REG_ADDR_W = 4,
    parameter int NUM_SRC    = 3
`ifdef HZ_STATS_EN
    , parameter int STAT_W   = 16
`endif
);
    logic [REG_ADDR_W-1:0]         RW_EX;
    logic [REG_ADDR_W-1:0]         RW_MEM;
    logic [REG_ADDR_W-1:0]         RW_WB;
    logic [NUM_SRC*REG_ADDR_W-1:0] SRC_ID;
    logic [NUM_SRC-1:0]            SRC_USE_ID;
    logic                          enable_LD_EX;
    logic                          enable_RF_EX;
    logic                          enable_RF_MEM;
    logic                          enable_RF_WB;
    logic                          FLUSH;
    logic [2*NUM_SRC-1:0]          FWD_SEL;
    logic                          C_Unit_MUX;
    logic                          HZld;
    logic                          IF_ID_ld;
`ifdef HZ_STATS_EN
    logic [STAT_W-1:0]             STALL_CNT;
`endif

    // The pipeline side drives the compare fields and consumes the controls.
    modport master (
        output RW_EX, RW_MEM, RW_WB, SRC_ID, SRC_USE_ID,
        output enable_LD_EX, enable_RF_EX, enable_RF_MEM, enable_RF_WB, FLUSH,
`ifdef HZ_STATS_EN
        input  STALL_CNT,
`endif
        input  FWD_SEL, C_Unit_MUX, HZld, IF_ID_ld
    );

    modport slave (
        input  RW_EX, RW_MEM, RW_WB, SRC_ID, SRC_USE_ID,
        input  enable_LD_EX, enable_RF_EX, enable_RF_MEM, enable_RF_WB, FLUSH,
`ifdef HZ_STATS_EN
        output STALL_CNT,
`endif
        output FWD_SEL, C_Unit_MUX, HZld, IF_ID_ld
    );
endinterface

// File: rtl/hazard_forward_unit.sv
// ID-stage forwarding select and load-use stall control for the RISC-ARM pipeline.
// Optional saturating stall statistics counter enabled by defining HZ_STATS_EN.
module hazard_forward_unit #(
    parameter int REG_ADDR_W = 4,
    parameter int NUM_SRC    = 3,
    parameter int LOAD_LAT   = 1
`ifdef HZ_STATS_EN
    , parameter int STAT_W   = 16
`endif
) (
    input logic                 CLK,
    input logic                 RST,
    hazard_forward_unit_if.slave bus
);

    if (LOAD_LAT < 1 || LOAD_LAT > 15) begin : g_bad_load_lat
        $error("hazard_forward_unit: LOAD_LAT must be in the range 1..15");
    end

    localparam logic [3:0] LAT_M1 = 4'(LOAD_LAT - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [3:0]           cnt;
    logic [3:0]           next_cnt;
    logic                 stall;
    logic                 src_hit;
    logic                 luh;
    logic [2*NUM_SRC-1:0] fwd_sel;

    // Youngest producer wins: EX over MEM over WB, independently per source.
    always_comb begin
        fwd_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (bus.SRC_USE_ID[i]) begin
                if (bus.enable_RF_EX && bus.RW_EX == bus.SRC_ID[i*REG_ADDR_W +: REG_ADDR_W])
                    fwd_sel[2*i +: 2] = 2'b01;
                else if (bus.enable_RF_MEM && bus.RW_MEM == bus.SRC_ID[i*REG_ADDR_W +: REG_ADDR_W])
                    fwd_sel[2*i +: 2] = 2'b10;
                else if (bus.enable_RF_WB && bus.RW_WB == bus.SRC_ID[i*REG_ADDR_W +: REG_ADDR_W])
                    fwd_sel[2*i +: 2] = 2'b11;
            end
        end
    end

    always_comb begin
        src_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (bus.SRC_USE_ID[i] && bus.SRC_ID[i*REG_ADDR_W +: REG_ADDR_W] == bus.RW_EX)
                src_hit = 1'b1;
        end
    end

    assign luh = bus.enable_LD_EX && src_hit && !bus.FLUSH;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Counter holds the stall cycles still to come after the current one.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                next_cnt = 4'd0;
                if (luh) begin
                    stall = 1'b1;
                    if (LOAD_LAT > 1) begin
                        next_state = WAIT;
                        next_cnt   = LAT_M1;
                    end
                end
            end
            WAIT: begin
                if (bus.FLUSH) begin
                    next_state = IDLE;
                    next_cnt   = 4'd0;
                end else begin
                    stall = 1'b1;
                    if (cnt == 4'd1) begin
                        next_state = IDLE;
                        next_cnt   = 4'd0;
                    end else begin
                        next_cnt = cnt - 4'd1;
                    end
                end
            end
            default: begin
                next_state = IDLE;
                next_cnt   = 4'd0;
            end
        endcase
    end

`ifdef HZ_STATS_EN
    logic [STAT_W-1:0] stall_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            stall_cnt <= '0;
        else if (stall && stall_cnt != '1)
            stall_cnt <= stall_cnt + STAT_W'(1);
    end

    assign bus.STALL_CNT = stall_cnt;
`endif

    // Reset overrides the combinational paths so the pipeline runs freely.
    assign bus.FWD_SEL    = RST ? '0 : fwd_sel;
    assign bus.C_Unit_MUX = RST | ~stall;
    assign bus.HZld       = RST | ~stall;
    assign bus.IF_ID_ld   = RST | ~stall;

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Parametrised hazard detection and forwarding unit for the ID stage of the RISC-ARM pipeline.
- Compares NUM_SRC ID-stage source register fields against the destination registers in EX, MEM and WB.
- Produces one 2-bit forwarding select per source, and stalls the pipeline on load-use hazards.
- Load-use stall length is LOAD_LAT cycles, held by a stall state machine with a cycle counter; a FLUSH input aborts an in-progress stall.

Parameters:
REG_ADDR_W, 4, width of a register address.
NUM_SRC, 3, number of ID-stage source fields (0 = Rn, 1 = Rm, 2 = store data Rd).
LOAD_LAT, 1, load-use stall cycles; legal range 1..15.
STAT_W, 16, width of the stall statistics counter (optional feature only).

Ports:
CLK  in  1  pipeline clock, rising edge.
RST  in  1  asynchronous reset, active-high.
RW_EX  in  REG_ADDR_W  destination register of the instruction in EX.
RW_MEM  in  REG_ADDR_W  destination register of the instruction in MEM.
RW_WB  in  REG_ADDR_W  destination register of the instruction in WB.
SRC_ID  in  NUM_SRC*REG_ADDR_W  packed ID source fields; source i is at bits [i*REG_ADDR_W +: REG_ADDR_W].
SRC_USE_ID  in  NUM_SRC  bit i=1: source i is actually read by the ID instruction.
enable_LD_EX  in  1  instruction in EX is a load.
enable_RF_EX  in  1  EX instruction writes the register file.
enable_RF_MEM  in  1  MEM instruction writes the register file.
enable_RF_WB  in  1  WB instruction writes the register file.
FLUSH  in  1  branch taken / pipeline flush this cycle.
FWD_SEL  out  2*NUM_SRC  per-source select at bits [2i+1:2i]: 00 = register file, 01 = EX, 10 = MEM, 11 = WB.
C_Unit_MUX  out  1  0 = inject NOP control word into ID/EX.
HZld  out  1  0 = hold the PC.
IF_ID_ld  out  1  0 = hold the IF/ID register.
STALL_CNT  out  STAT_W  total stall cycles (present only with HZ_STATS_EN).

Behaviour:
- Reset (RST=1, asynchronous):
  - FSM goes to IDLE; counter = 0; STALL_CNT = 0.
  - While RST=1, outputs are forced to: C_Unit_MUX = HZld = IF_ID_ld = 1, FWD_SEL = all 00.
- Forwarding (combinational, zero latency, evaluated independently per source i):
  - A source takes part only if SRC_USE_ID[i] = 1; otherwise its select is 00.
  - Priority is EX > MEM > WB:
    - select 01 if enable_RF_EX and RW_EX == src_i;
    - else 10 if enable_RF_MEM and RW_MEM == src_i;
    - else 11 if enable_RF_WB and RW_WB == src_i;
    - else 00.
  - Forwarding is computed in every state, including during a stall.
- Load-use detection (combinational):
  - luh = enable_LD_EX AND (for some i: SRC_USE_ID[i] AND src_i == RW_EX) AND NOT FLUSH.
- FSM states: IDLE, WAIT. Stall outputs (C_Unit_MUX, HZld, IF_ID_ld) are all 0 exactly when stall = (state==IDLE AND luh) OR (state==WAIT AND NOT FLUSH).
- IDLE:
  - If luh and LOAD_LAT > 1: next state WAIT, counter <= LOAD_LAT-1.
  - If luh and LOAD_LAT == 1: stay in IDLE (single bubble cycle).
- WAIT:
  - Stall held regardless of the compare inputs.
  - Counter decrements every cycle; when counter == 1, next state is IDLE and counter <= 0.
  - Total stall for one hazard is exactly LOAD_LAT consecutive cycles.
- FLUSH = 1 in any state:
  - Stall outputs are deasserted in that same cycle.
  - Next state is IDLE and counter <= 0.
  - FLUSH has priority over luh.
- A new luh seen during WAIT is ignored; re-detection happens in IDLE on the following cycle.
- Reset asserted mid-WAIT returns the FSM to IDLE immediately, with no further stall cycles.
- Width rules:
  - The counter is 4 bits.
  - LOAD_LAT == 0 or LOAD_LAT > 15 is illegal; an elaboration-time check flags it.

Optional Feature:
- Macro: HZ_STATS_EN.
- Defined:
  - STALL_CNT port exists.
  - Increments by 1 on every rising edge where stall = 1.
  - Saturates at all-ones; cleared only by RST.
- Undefined: no STALL_CNT port and no counter logic; all other behaviour is identical.

Test Plan:
- Forwarding priority: NUM_SRC=3, SRC_ID = {C=4'h3, Rm=4'h2, Rn=4'h2}, SRC_USE_ID = 3'b111, RW_EX=2 and RW_MEM=2 and RW_WB=3 with all enable_RF=1 -> FWD_SEL = 6'b11_01_01. Then drop enable_RF_EX -> 6'b11_10_10.
- Unused source: Rm=5, SRC_USE_ID[1]=0, RW_EX=5, enable_RF_EX=1, enable_LD_EX=1 -> FWD_SEL[3:2] = 00, no stall.
- LOAD_LAT=1: enable_LD_EX=1, RW_EX=7, Rn=7 for one cycle -> C_Unit_MUX = HZld = IF_ID_ld = 0 for exactly 1 cycle, FSM stays IDLE. Next cycle RW_MEM=7, enable_RF_MEM=1 -> FWD_SEL[1:0] = 10.
- LOAD_LAT=3: same hazard pulse for one cycle, then inputs cleared -> stall is 0 for exactly 3 consecutive cycles, then 1. With HZ_STATS_EN, STALL_CNT = 3.
- LOAD_LAT=4: FLUSH=1 on the 2nd stall cycle -> stall outputs return to 1 in that cycle, FSM in IDLE at the next edge. STALL_CNT = 1.
- Reset mid-WAIT: LOAD_LAT=4, assert RST asynchronously in the 2nd stall cycle -> stall outputs = 1 immediately, FWD_SEL = 0, STALL_CNT = 0. After release, no residual stall.
